sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the number of cycles without m_ack before an access is aborted (8-bit counter).
REQ-002 SHALL have clk  in  1  rising-edge clock.
REQ-003 SHALL have rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have flush  in  1  pipeline flush from ctrl; cancels all pending work.
REQ-005 SHALL have i_ce, i_addr  in  1/32  fetch request and word address.
REQ-006 SHALL have i_stall  in  1  IF-stage stall from ctrl.
REQ-007 SHALL have i_rdata, i_stallreq  out  32/1  fetched word and stall request.
REQ-008 SHALL have d_ce, d_we, d_addr, d_wdata, d_sel  in  1/1/32/32/4  MEM-stage access; d_we is already exception-gated.
REQ-009 SHALL have d_stall  in  1  MEM-stage stall from ctrl.
REQ-010 SHALL have d_rdata, d_stallreq  out  32/1  load word and stall request.
REQ-011 SHALL have m_cyc, m_stb, m_we, m_addr, m_wdata, m_sel  out  1/1/1/32/32/4  registered master port to the shared single-port memory.
REQ-012 SHALL have m_rdata, m_ack  in  32/1  slave read data and completion.
REQ-013 SHALL have bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-014 SHALL implement the FSM states IDLE, D_ACC and I_ACC.
REQ-015 Pending is defined per port: i_pend = i_ce & ~i_done, and d_pend = d_ce & ~d_done.
REQ-016 From IDLE, when d_pend and no flush, the FSM SHALL go to D_ACC; otherwise, when i_pend, it SHALL go to I_ACC; otherwise it stays in IDLE. The data port has fixed priority.
REQ-017 On entry to an ACC state, m_cyc and m_stb SHALL rise in the next cycle, with m_we, m_addr, m_wdata and m_sel registered from the winning port. For I_ACC: m_we=0 and m_sel=4'b1111.
REQ-018 In an ACC state, when m_ack=1: drop m_cyc/m_stb in the next cycle, capture m_rdata into the port buffer, set the port's done flag, and return to IDLE.
REQ-019 Master outputs SHALL stay stable while m_cyc=1 and m_ack=0.
REQ-020 i_stallreq SHALL equal i_pend and d_stallreq SHALL equal d_pend, both combinational.
REQ-021 i_rdata/d_rdata SHALL be driven from the buffers. A buffer holds its value until it is overwritten by the next capture for that port.
REQ-022 When done=1 and the port's stall input is 0, done SHALL clear in the next cycle, because the pipeline has advanced.
REQ-023 Minimum stall SHALL be 2 cycles: request seen at T0, m_stb at T1, same-cycle ack at T1, stallreq low at T2.
REQ-024 When flush=1:
  - next cycle: m_cyc, m_stb and m_we are 0, the FSM is in IDLE, and both done flags are 0;
  - an m_ack in the flush cycle is ignored, with no buffer write and no done set.
REQ-025 Flush and a new request in the same cycle: the flush wins; the request is re-evaluated after that.
REQ-026 A request that drops while its access is in ACC SHALL still complete the bus cycle; the result is captured but done is not set.
REQ-027 When both ports are pending in IDLE, D_ACC is chosen. I_ACC follows after d completion without any idle bus cycle beyond the one IDLE cycle.

Reset
REQ-028 When rst_n=0 at a clock edge, the block SHALL reset to:
  - FSM in IDLE;
  - m_cyc, m_stb, m_we = 0; m_addr, m_wdata = 0; m_sel = 4'b0000;
  - i_rdata, d_rdata = 0; done flags = 0; timeout counter = 0; bus_err = 0.
REQ-029 Reset SHALL take priority over flush and m_ack, including mid-access.

Configuration
REQ-030 With ARB_TIMEOUT_EN defined:
  - the counter increments each ACC cycle without ack;
  - when it reaches TIMEOUT_CYCLES, the access is aborted as in REQ-018 but with buffer=0, and bus_err pulses for 1 cycle.
REQ-031 Without ARB_TIMEOUT_EN, there SHALL be no counter, ACC SHALL wait indefinitely, and bus_err SHALL be tied 0.

Verification
REQ-032 i_ce=1, i_addr=0x100, m_ack one cycle after m_stb with m_rdata=0x3C011234 -> m_addr=0x100, m_we=0; i_stallreq high for 3 cycles; i_rdata=0x3C011234.
REQ-033 i_ce and d_ce (d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_sel=4'b0011) both asserted at T0 -> the store is issued first with m_sel=4'b0011, then the fetch; d_stallreq clears before i_stallreq.
REQ-034 flush at the 2nd cycle of D_ACC with no ack -> m_cyc=0 next cycle, d_rdata unchanged, FSM in IDLE; an ack in the flush cycle is ignored.
REQ-035 Load completes while d_stall=1 for 3 cycles -> d_stallreq stays 0, d_rdata is held, no second bus cycle, done clears after d_stall falls.
REQ-036 ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> abort after 4 ACC cycles, bus_err=1 for one cycle, d_rdata=0; without the macro, m_cyc stays 1.
REQ-037 rst_n=0 during I_ACC -> every output listed in REQ-028 is at its reset value next cycle.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Bundle between the IF/MEM pipeline stages, the arbiter and the shared single-port memory.
// The master modport is the arbiter's view; the slave modport is the surrounding pipeline/memory.
interface sram_port_arbiter_if;
    logic        flush;
    logic        i_ce;
    logic [31:0] i_addr;
    logic        i_stall;
    logic [31:0] i_rdata;
    logic        i_stallreq;
    logic        d_ce;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic        d_stall;
    logic [31:0] d_rdata;
    logic        d_stallreq;
    logic        m_cyc;
    logic        m_stb;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_sel;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        bus_err;

    modport master (
        input  flush, i_ce, i_addr, i_stall,
        input  d_ce, d_we, d_addr, d_wdata, d_sel, d_stall,
        input  m_rdata, m_ack,
        output i_rdata, i_stallreq, d_rdata, d_stallreq,
        output m_cyc, m_stb, m_we, m_addr, m_wdata, m_sel, bus_err
    );

    modport slave (
        output flush, i_ce, i_addr, i_stall,
        output d_ce, d_we, d_addr, d_wdata, d_sel, d_stall,
        output m_rdata, m_ack,
        input  i_rdata, i_stallreq, d_rdata, d_stallreq,
        input  m_cyc, m_stb, m_we, m_addr, m_wdata, m_sel, bus_err
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Arbitrates the fetch (i) and load/store (d) ports onto one registered memory master, data port first.
// Optional access timeout with bus_err pulse is enabled by defining ARB_TIMEOUT_EN.
module sram_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_port_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    logic        m_cyc_reg;
    logic        m_stb_reg;
    logic        m_we_reg;
    logic [31:0] m_addr_reg;
    logic [31:0] m_wdata_reg;
    logic [3:0]  m_sel_reg;
    logic [31:0] i_rdata_reg;
    logic [31:0] d_rdata_reg;
    logic        i_done_reg;
    logic        d_done_reg;

    logic        i_pend;
    logic        d_pend;
    logic        tmo_hit;
    logic [31:0] cap_data;

    assign i_pend = bus.i_ce & ~i_done_reg;
    assign d_pend = bus.d_ce & ~d_done_reg;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_reg;
    logic       bus_err_reg;

    // An aborted access completes like an ack but delivers zero data.
    assign tmo_hit  = ~bus.m_ack & (tmo_cnt_reg == TMO_LAST);
    assign cap_data = bus.m_ack ? bus.m_rdata : 32'h0;
    assign bus.bus_err = bus_err_reg;
`else
    logic unused_tmo;

    assign unused_tmo  = ^TMO_LAST;
    assign tmo_hit     = 1'b0;
    assign cap_data    = bus.m_rdata;
    assign bus.bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            m_cyc_reg   <= 1'b0;
            m_stb_reg   <= 1'b0;
            m_we_reg    <= 1'b0;
            m_addr_reg  <= 32'h0;
            m_wdata_reg <= 32'h0;
            m_sel_reg   <= 4'b0000;
            i_rdata_reg <= 32'h0;
            d_rdata_reg <= 32'h0;
            i_done_reg  <= 1'b0;
            d_done_reg  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_reg <= 8'h0;
            bus_err_reg <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            bus_err_reg <= 1'b0;
`endif
            // A done flag only lives until the owning stage advances.
            if (i_done_reg && !bus.i_stall) i_done_reg <= 1'b0;
            if (d_done_reg && !bus.d_stall) d_done_reg <= 1'b0;

            if (bus.flush) begin
                state_reg  <= IDLE;
                m_cyc_reg  <= 1'b0;
                m_stb_reg  <= 1'b0;
                m_we_reg   <= 1'b0;
                i_done_reg <= 1'b0;
                d_done_reg <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                tmo_cnt_reg <= 8'h0;
`endif
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (d_pend) begin
                            state_reg   <= D_ACC;
                            m_cyc_reg   <= 1'b1;
                            m_stb_reg   <= 1'b1;
                            m_we_reg    <= bus.d_we;
                            m_addr_reg  <= bus.d_addr;
                            m_wdata_reg <= bus.d_wdata;
                            m_sel_reg   <= bus.d_sel;
                        end else if (i_pend) begin
                            state_reg  <= I_ACC;
                            m_cyc_reg  <= 1'b1;
                            m_stb_reg  <= 1'b1;
                            m_we_reg   <= 1'b0;
                            m_addr_reg <= bus.i_addr;
                            m_sel_reg  <= 4'b1111;
                        end
                    end
                    D_ACC, I_ACC: begin
                        if (bus.m_ack || tmo_hit) begin
                            state_reg <= IDLE;
                            m_cyc_reg <= 1'b0;
                            m_stb_reg <= 1'b0;
                            m_we_reg  <= 1'b0;
                            // A request withdrawn mid-access still captures, but is not marked done.
                            if (state_reg == D_ACC) begin
                                d_rdata_reg <= cap_data;
                                d_done_reg  <= bus.d_ce;
                            end else begin
                                i_rdata_reg <= cap_data;
                                i_done_reg  <= bus.i_ce;
                            end
`ifdef ARB_TIMEOUT_EN
                            tmo_cnt_reg <= 8'h0;
                            bus_err_reg <= tmo_hit;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + 8'h1;
`endif
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.m_cyc      = m_cyc_reg;
    assign bus.m_stb      = m_stb_reg;
    assign bus.m_we       = m_we_reg;
    assign bus.m_addr     = m_addr_reg;
    assign bus.m_wdata    = m_wdata_reg;
    assign bus.m_sel      = m_sel_reg;
    assign bus.i_rdata    = i_rdata_reg;
    assign bus.d_rdata    = d_rdata_reg;
    assign bus.i_stallreq = i_pend;
    assign bus.d_stallreq = d_pend;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed test of sram_port_arbiter: fetch, store+fetch priority, stalled load, flush, timeout, reset.
module tb_sram_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    sram_port_arbiter_if bus ();

    sram_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.flush = 1'b0;   bus.i_ce = 1'b0;   bus.i_addr = 32'h0;  bus.i_stall = 1'b0;
        bus.d_ce = 1'b0;    bus.d_we = 1'b0;   bus.d_addr = 32'h0;  bus.d_wdata = 32'h0;
        bus.d_sel = 4'h0;   bus.d_stall = 1'b0; bus.m_rdata = 32'h0; bus.m_ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_m_cyc", 32'(bus.m_cyc), 32'h0);
        chk("rst_m_sel", 32'(bus.m_sel), 32'h0);
        chk("rst_m_addr", bus.m_addr, 32'h0);
        chk("rst_bus_err", 32'(bus.bus_err), 32'h0);
        $display("step: reset released");

        // Fetch with ack one cycle after strobe
        bus.i_ce = 1'b1; bus.i_addr = 32'h100; #1;
        chk("f_stallreq_t0", 32'(bus.i_stallreq), 32'h1);
        chk("f_cyc_t0", 32'(bus.m_cyc), 32'h0);
        tick();
        chk("f_stb_t1", 32'(bus.m_stb), 32'h1);
        chk("f_addr_t1", bus.m_addr, 32'h100);
        chk("f_we_t1", 32'(bus.m_we), 32'h0);
        chk("f_sel_t1", 32'(bus.m_sel), 32'hF);
        tick();
        bus.m_ack = 1'b1; bus.m_rdata = 32'h3C011234; #1;
        chk("f_stallreq_t2", 32'(bus.i_stallreq), 32'h1);
        chk("f_cyc_t2", 32'(bus.m_cyc), 32'h1);
        tick();
        bus.m_ack = 1'b0; #1;
        chk("f_stallreq_t3", 32'(bus.i_stallreq), 32'h0);
        chk("f_cyc_t3", 32'(bus.m_cyc), 32'h0);
        chk("f_rdata", bus.i_rdata, 32'h3C011234);
        bus.i_ce = 1'b0;
        $display("step: fetch 0x100 done");
        tick();

        // Store and fetch together: store wins
        bus.i_ce = 1'b1; bus.i_addr = 32'h104;
        bus.d_ce = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF; bus.d_sel = 4'b0011;
        bus.m_rdata = 32'h0;
        tick();
        chk("sf_we", 32'(bus.m_we), 32'h1);
        chk("sf_addr_d", bus.m_addr, 32'h200);
        chk("sf_wdata", bus.m_wdata, 32'hDEADBEEF);
        chk("sf_sel_d", 32'(bus.m_sel), 32'h3);
        bus.m_ack = 1'b1;
        tick();
        bus.m_ack = 1'b0; #1;
        chk("sf_d_stallreq", 32'(bus.d_stallreq), 32'h0);
        chk("sf_i_stallreq", 32'(bus.i_stallreq), 32'h1);
        chk("sf_cyc_idle", 32'(bus.m_cyc), 32'h0);
        bus.d_ce = 1'b0; bus.d_we = 1'b0;
        tick();
        chk("sf_cyc_i", 32'(bus.m_cyc), 32'h1);
        chk("sf_addr_i", bus.m_addr, 32'h104);
        chk("sf_we_i", 32'(bus.m_we), 32'h0);
        chk("sf_sel_i", 32'(bus.m_sel), 32'hF);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h11112222;
        tick();
        bus.m_ack = 1'b0; #1;
        chk("sf_i_done", 32'(bus.i_stallreq), 32'h0);
        chk("sf_i_rdata", bus.i_rdata, 32'h11112222);
        bus.i_ce = 1'b0;
        $display("step: store 0x200 then fetch 0x104");
        tick();

        // Fetch withdrawn mid-access: captured but not done
        bus.i_ce = 1'b1; bus.i_addr = 32'h108;
        tick();
        bus.i_ce = 1'b0; bus.m_ack = 1'b1; bus.m_rdata = 32'h55AA55AA;
        tick();
        bus.m_ack = 1'b0; bus.i_ce = 1'b1; #1;
        chk("wd_rdata", bus.i_rdata, 32'h55AA55AA);
        chk("wd_not_done", 32'(bus.i_stallreq), 32'h1);
        bus.i_ce = 1'b0;
        $display("step: withdrawn fetch 0x108");
        tick();

        // Load completing under d_stall
        bus.d_ce = 1'b1; bus.d_addr = 32'h300; bus.d_sel = 4'hF; bus.d_stall = 1'b1;
        tick();
        chk("ld_addr", bus.m_addr, 32'h300);
        chk("ld_we", 32'(bus.m_we), 32'h0);
        bus.m_ack = 1'b1; bus.m_rdata = 32'hCAFEF00D;
        tick();
        bus.m_ack = 1'b0; bus.m_rdata = 32'h0; #1;
        chk("ld_rdata", bus.d_rdata, 32'hCAFEF00D);
        for (int k = 0; k < 3; k++) begin
            chk("ld_stallreq_held", 32'(bus.d_stallreq), 32'h0);
            chk("ld_no_rebus", 32'(bus.m_cyc), 32'h0);
            tick();
        end
        bus.d_stall = 1'b0; #1;
        chk("ld_done_last", 32'(bus.d_stallreq), 32'h0);
        tick();
        chk("ld_done_clr", 32'(bus.d_stallreq), 32'h1);
        chk("ld_rdata_hold", bus.d_rdata, 32'hCAFEF00D);
        bus.d_addr = 32'h304;
        $display("step: stalled load 0x300");

        // Flush in 2nd D_ACC cycle, with an ack that must be ignored
        tick();
        chk("fl_cyc_acc1", 32'(bus.m_cyc), 32'h1);
        tick();
        bus.flush = 1'b1; bus.m_ack = 1'b1; bus.m_rdata = 32'h99999999;
        tick();
        bus.flush = 1'b0; bus.m_ack = 1'b0; #1;
        chk("fl_cyc", 32'(bus.m_cyc), 32'h0);
        chk("fl_stb", 32'(bus.m_stb), 32'h0);
        chk("fl_rdata_kept", bus.d_rdata, 32'hCAFEF00D);
        chk("fl_no_done", 32'(bus.d_stallreq), 32'h1);
        tick();
        chk("fl_reissue", 32'(bus.m_cyc), 32'h1);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h0BADF00D;
        tick();
        bus.m_ack = 1'b0; bus.d_ce = 1'b0; #1;
        chk("fl_reissue_rdata", bus.d_rdata, 32'h0BADF00D);
        $display("step: flush during load 0x304");

        // Flush and new fetch in the same IDLE cycle
        bus.i_ce = 1'b1; bus.i_addr = 32'h10C; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; #1;
        chk("fr_flush_wins", 32'(bus.m_cyc), 32'h0);
        tick();
        chk("fr_reeval", 32'(bus.m_cyc), 32'h1);
        bus.i_ce = 1'b0; bus.m_ack = 1'b1; bus.m_rdata = 32'h0;
        tick();
        bus.m_ack = 1'b0;
        $display("step: flush with simultaneous fetch");
        tick();

        // Access with no ack: timeout abort or indefinite wait
        bus.d_ce = 1'b1; bus.d_addr = 32'h400;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("to_waiting", 32'(bus.m_cyc), 32'h1);
            chk("to_no_err", 32'(bus.bus_err), 32'h0);
            tick();
        end
`ifdef ARB_TIMEOUT_EN
        chk("to_abort_cyc", 32'(bus.m_cyc), 32'h0);
        chk("to_bus_err", 32'(bus.bus_err), 32'h1);
        chk("to_rdata_zero", bus.d_rdata, 32'h0);
        chk("to_done", 32'(bus.d_stallreq), 32'h0);
        bus.d_ce = 1'b0;
        tick();
        chk("to_err_pulse", 32'(bus.bus_err), 32'h0);
`else
        tick(); tick();
        chk("to_still_cyc", 32'(bus.m_cyc), 32'h1);
        chk("to_err_tied", 32'(bus.bus_err), 32'h0);
        bus.d_ce = 1'b0; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
`endif
        $display("step: no-ack load 0x400");

        // Give d_rdata a non-zero value, then reset in the middle of I_ACC
        bus.d_ce = 1'b1; bus.d_addr = 32'h500; bus.d_wdata = 32'hDEADBEEF;
        tick();
        bus.m_ack = 1'b1; bus.m_rdata = 32'h77776666;
        tick();
        bus.m_ack = 1'b0; bus.d_ce = 1'b0; #1;
        chk("pre_rst_drdata", bus.d_rdata, 32'h77776666);
        bus.i_ce = 1'b1; bus.i_addr = 32'h110;
        tick();
        chk("pre_rst_cyc", 32'(bus.m_cyc), 32'h1);
        rst_n = 1'b0; bus.m_ack = 1'b1; bus.flush = 1'b1;
        tick();
        bus.m_ack = 1'b0; bus.flush = 1'b0; bus.i_ce = 1'b0; #1;
        chk("rs_cyc", 32'(bus.m_cyc), 32'h0);
        chk("rs_stb", 32'(bus.m_stb), 32'h0);
        chk("rs_we", 32'(bus.m_we), 32'h0);
        chk("rs_addr", bus.m_addr, 32'h0);
        chk("rs_wdata", bus.m_wdata, 32'h0);
        chk("rs_sel", 32'(bus.m_sel), 32'h0);
        chk("rs_i_rdata", bus.i_rdata, 32'h0);
        chk("rs_d_rdata", bus.d_rdata, 32'h0);
        chk("rs_bus_err", 32'(bus.bus_err), 32'h0);
        rst_n = 1'b1;
        $display("step: reset during fetch 0x110");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
